// File: rtl/shader_pkg.sv
// Shared types and constants for the shader instruction fetch unit.
// Holds control-flow opcodes, fetch FSM states and the instruction word type.
package shader_pkg;

    localparam logic [5:0] OP_BRANCH      = 6'h38;
    localparam logic [5:0] OP_BRANCH_COND = 6'h39;
    localparam logic [5:0] OP_CALL        = 6'h3A;
    localparam logic [5:0] OP_RET         = 6'h3B;
    localparam logic [5:0] OP_BARRIER     = 6'h3C;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_HALT
    } state_t;

    typedef logic [63:0] instr_t;

    // Any control-flow opcode stops sequential fetch until resolved.
    function automatic logic is_cf(logic [5:0] op);
        return (op >= OP_BRANCH) && (op <= OP_BARRIER);
    endfunction

    function automatic logic [31:0] align8(logic [31:0] a);
        return a & 32'hFFFF_FFF8;
    endfunction

endpackage

// File: rtl/shader_ifetch_fifo.sv
// Instruction buffer between imem responses and the shader core.
// Ports: push/push_data in, pop in, flush in, head/count/full/empty out.
module shader_ifetch_fifo
    import shader_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [63:0]              push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [63:0]              head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    instr_t          mem [DEPTH];
    logic [AW-1:0]   wr_q;
    logic [AW-1:0]   rd_q;
    logic [CW-1:0]   cnt_q;
    logic            do_push;
    logic            do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CW'(DEPTH));
    assign count   = cnt_q;
    assign head    = empty ? 64'h0 : mem[rd_q];
    // Flush wins over a same-cycle push; pop is ignored when empty.
    assign do_push = push && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_q] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                wr_q <= wr_q + AW'(1);
            end
            if (do_pop) begin
                rd_q <= rd_q + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/shader_ifetch.sv
// Shader instruction fetch: issues imem requests, buffers responses, halts on control flow.
// Ports: start/redirect/resume control, imem req/gnt/rvalid bus, instruction/valid/ready to core, busy/cf_halted.
module shader_ifetch
    import shader_pkg::*;
#(
    parameter int FIFO_DEPTH      = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] start_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        resume,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [63:0] imem_rdata,
    output logic [63:0] instruction,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        busy,
    output logic        cf_halted
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 2) + 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t          state_q;
    state_t          state_d;
    logic [31:0]     pc_q;
    logic [31:0]     resp_pc_q;
    logic [OW-1:0]   out_q;
    logic [OW-1:0]   disc_q;
    logic [OW-1:0]   out_d;
    logic [OW-1:0]   inflight;
    logic            req_pend_q;
    logic            req_stale_q;
    logic [31:0]     req_addr_q;
    logic [CW-1:0]   fifo_count;
    logic            fifo_full;
    logic            fifo_empty;
    logic            has_room;
    logic            issue_new;
    logic            grant;
    logic            live_grant;
    logic            pend_d;
    logic            rsp;
    logic            drop;
    logic            keep;
    logic            redirect_take;
    logic            resume_take;
    logic            cf_take;
    logic            kill;

    assign has_room = !fifo_full
        && (32'(out_q) + 32'(fifo_count) < 32'(FIFO_DEPTH))
        && (32'(out_q) < 32'(MAX_OUTSTANDING));
    // A held request blocks any new address until it is granted.
    assign issue_new  = (state_q == ST_FETCH) && !req_pend_q && has_room;
    assign grant      = imem_req && imem_gnt;
    // A held request orphaned by redirect/halt must not advance pc.
    assign live_grant = grant && !(req_pend_q && req_stale_q);
    assign pend_d     = imem_req && !imem_gnt;
    // Responses with nothing outstanding are leftovers from before reset.
    assign rsp        = imem_rvalid && (out_q != '0);
    assign drop       = rsp && (disc_q != '0);
    assign keep       = rsp && (disc_q == '0);

    assign redirect_take = redirect_valid && (state_q != ST_IDLE);
    assign resume_take   = resume && (state_q == ST_HALT) && !redirect_valid;
    assign cf_take       = keep && is_cf(imem_rdata[63:58])
        && (state_q == ST_FETCH) && !redirect_valid;
    assign kill          = redirect_take || cf_take;

    always_comb begin
        out_d = out_q;
        if (grant && !rsp) begin
            out_d = out_q + OW'(1);
        end else if (!grant && rsp) begin
            out_d = out_q - OW'(1);
        end
        // Everything still to come back, including an ungranted held request.
        inflight = out_d + {{(OW-1){1'b0}}, pend_d};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (redirect_take) state_d = ST_FETCH;
                else if (cf_take)  state_d = ST_HALT;
            end
            ST_HALT: begin
                if (redirect_take || resume_take) state_d = ST_FETCH;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        imem_req  = req_pend_q || issue_new;
        imem_addr = 32'h0;
        if (req_pend_q) begin
            imem_addr = req_addr_q;
        end else if (issue_new) begin
            imem_addr = pc_q;
        end
        cf_halted = (state_q == ST_HALT);
        busy      = (state_q != ST_IDLE) || !fifo_empty
            || (out_q != '0) || (disc_q != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= 32'h0;
            resp_pc_q   <= 32'h0;
            out_q       <= '0;
            disc_q      <= '0;
            req_pend_q  <= 1'b0;
            req_stale_q <= 1'b0;
            req_addr_q  <= 32'h0;
        end else begin
            out_q       <= out_d;
            req_pend_q  <= pend_d;
            req_stale_q <= pend_d && ((req_pend_q && req_stale_q) || kill);
            if (issue_new) begin
                req_addr_q <= pc_q;
            end
            if ((state_q == ST_IDLE) && start) begin
                pc_q      <= align8(start_pc);
                resp_pc_q <= align8(start_pc);
            end else if (redirect_take) begin
                pc_q      <= align8(redirect_pc);
                resp_pc_q <= align8(redirect_pc);
                disc_q    <= inflight;
            end else if (cf_take) begin
                pc_q      <= resp_pc_q + 32'd8;
                resp_pc_q <= resp_pc_q + 32'd8;
                disc_q    <= inflight;
            end else begin
                if (live_grant) pc_q <= pc_q + 32'd8;
                if (keep) resp_pc_q <= resp_pc_q + 32'd8;
                if (drop) disc_q <= disc_q - OW'(1);
            end
        end
    end

    shader_ifetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (keep),
        .push_data (imem_rdata),
        .pop       (instr_ready),
        .flush     (redirect_take),
        .head      (instruction),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign instr_valid = !fifo_empty;

endmodule

// File: tb/tb_shader_ifetch.sv
// Scoreboard bench for shader_ifetch with a 1-cycle in-order imem model.
// Expected words/addresses are queued by stimulus and popped by monitors.
module tb_shader_ifetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] start_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        resume;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid = 1'b0;
    logic [63:0] imem_rdata = 64'h0;
    logic [63:0] instruction;
    logic        instr_valid;
    logic        instr_ready;
    logic        busy;
    logic        cf_halted;

    int          checks = 0;
    int          failures = 0;
    int          grant_cnt = 0;
    logic        rsp_hold = 1'b0;
    logic [31:0] cf_addr = 32'h1;
    logic [5:0]  cf_op = 6'h38;
    logic [63:0] exp_q[$];
    logic [31:0] ea_q[$];
    logic [31:0] rq[$];

    shader_ifetch dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .start_pc       (start_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .resume         (resume),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .instruction    (instruction),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .busy           (busy),
        .cf_halted      (cf_halted)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] mem_word(input logic [31:0] a);
        return {((a == cf_addr) ? cf_op : 6'h01), 26'h0, a};
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // imem model: response one cycle after grant, in order.
    always @(negedge clk) begin
        #1;
        if (!rsp_hold && rq.size() > 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(rq.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 64'h0;
        end
        if (imem_req && imem_gnt) begin
            grant_cnt++;
            rq.push_back(imem_addr);
            if (ea_q.size() > 0) begin
                check("grant_addr", 64'(imem_addr), 64'(ea_q.pop_front()));
            end
        end
    end

    // Delivery monitor.
    always @(negedge clk) begin
        #1;
        if (instr_valid && instr_ready && exp_q.size() > 0) begin
            check("instr_out", instruction, exp_q.pop_front());
        end
    end

    task automatic push_words(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(mem_word(base + 32'(8 * i)));
    endtask

    task automatic push_addrs(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) ea_q.push_back(base + 32'(8 * i));
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_req"},   64'(imem_req), 64'h0);
        check({tag, "_addr"},  64'(imem_addr), 64'h0);
        check({tag, "_instr"}, instruction, 64'h0);
        check({tag, "_valid"}, 64'(instr_valid), 64'h0);
        check({tag, "_busy"},  64'(busy), 64'h0);
        check({tag, "_halt"},  64'(cf_halted), 64'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b0; start_pc = 32'h0;
        redirect_valid = 1'b0; redirect_pc = 32'h0; resume = 1'b0;
        imem_gnt = 1'b1; instr_ready = 1'b1; rsp_hold = 1'b0;
        cf_addr = 32'h1;
        exp_q.delete(); ea_q.delete(); rq.delete();
        @(negedge clk);
        check_zero_outputs("reset");
        rq.delete();
        grant_cnt = 0;
        rst = 1'b0;
    endtask

    task automatic pulse_start(input logic [31:0] pc);
        start_pc = pc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || ea_q.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 300) begin
            failures++;
            $display("FAIL %s: timeout words_left=%0d addrs_left=%0d want 0",
                     name, exp_q.size(), ea_q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; start_pc = 32'h0;
        redirect_valid = 1'b0; redirect_pc = 32'h0; resume = 1'b0;
        imem_gnt = 1'b1; instr_ready = 1'b1;

        // Sequential stream, back-to-back delivery.
        do_reset();
        push_addrs(32'h1000, 6);
        push_words(32'h1000, 6);
        pulse_start(32'h1000);
        wait_drain("t1_stream");
        check("t1_busy", 64'(busy), 64'h1);

        // Core stalled: buffer fills, request count bounded.
        do_reset();
        instr_ready = 1'b0;
        push_addrs(32'h1000, 8);
        push_words(32'h1000, 8);
        pulse_start(32'h1000);
        repeat (20) @(negedge clk);
        check("t2_grants", 64'(grant_cnt), 64'd4);
        check("t2_valid", 64'(instr_valid), 64'h1);
        check("t2_head", instruction, mem_word(32'h1000));
        check("t2_no_req", 64'(imem_req), 64'h0);
        instr_ready = 1'b1;
        wait_drain("t2_drain");

        // Branch at 0x1010 halts, redirect to 0x2000 (low bits ignored).
        do_reset();
        cf_addr = 32'h1010; cf_op = 6'h38;
        push_addrs(32'h1000, 4);
        push_words(32'h1000, 3);
        pulse_start(32'h1000);
        wait_drain("t3_pre");
        repeat (3) @(negedge clk);
        check("t3_halted", 64'(cf_halted), 64'h1);
        check("t3_halt_req", 64'(imem_req), 64'h0);
        check("t3_halt_valid", 64'(instr_valid), 64'h0);
        push_addrs(32'h2000, 2);
        push_words(32'h2000, 3);
        redirect_pc = 32'h2005; redirect_valid = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b0;
        check("t3_unhalted", 64'(cf_halted), 64'h0);
        wait_drain("t3_post");

        // Conditional branch at 0x1008, resume continues at 0x1010.
        do_reset();
        cf_addr = 32'h1008; cf_op = 6'h39;
        push_addrs(32'h1000, 3);
        push_words(32'h1000, 2);
        pulse_start(32'h1000);
        wait_drain("t4_pre");
        repeat (3) @(negedge clk);
        check("t4_halted", 64'(cf_halted), 64'h1);
        push_addrs(32'h1010, 2);
        push_words(32'h1010, 2);
        resume = 1'b1;
        @(negedge clk);
        resume = 1'b0;
        wait_drain("t4_post");

        // Redirect with 3 outstanding and a held ungranted request.
        do_reset();
        rsp_hold = 1'b1;
        push_addrs(32'h1000, 4);
        push_addrs(32'h2000, 2);
        push_words(32'h2000, 3);
        pulse_start(32'h1000);
        for (int n = 0; n < 50 && grant_cnt < 3; n++) @(negedge clk);
        check("t5_granted", 64'(grant_cnt), 64'd3);
        imem_gnt = 1'b0;
        @(negedge clk);
        check("t5_pend_req", 64'(imem_req), 64'h1);
        check("t5_pend_addr", 64'(imem_addr), 64'h1018);
        redirect_pc = 32'h2000; redirect_valid = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b0;
        check("t5_held_req", 64'(imem_req), 64'h1);
        check("t5_held_addr", 64'(imem_addr), 64'h1018);
        imem_gnt = 1'b1; rsp_hold = 1'b0;
        wait_drain("t5_post");

        // Address wrap, then reset in the middle of fetching.
        do_reset();
        push_addrs(32'hFFFF_FFF8, 3);
        push_words(32'hFFFF_FFF8, 3);
        pulse_start(32'hFFFF_FFF8);
        wait_drain("t6_wrap");
        rst = 1'b1;
        @(negedge clk);
        check_zero_outputs("t6_midrst");
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("t6_idle_valid", 64'(instr_valid), 64'h0);
        check("t6_idle_busy", 64'(busy), 64'h0);
        check("t6_idle_req", 64'(imem_req), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
